sdma_rdata_pack: RTL and testbench

Downstream of the source-port read-data mux. It takes the selected source port's data bus and its per-byte valid mask, and compacts the valid bytes into a contiguous byte stream. It emits full-width words with a byte-enable to the destination write path over a valid/ready handshake. It also tracks the instruction byte count and signals completion once every byte has been drained.

---
 rtl/sdma_rdata_pack.sv | 207 ++++++++++++++++++++
 tb/tb_sdma_rdata_pack.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdma_rdata_pack.sv
// Source-port read-data packer: compacts masked input bytes into full output words.
// Optional build macro SDMA_PACK_ERRCHK_EN adds contiguity/overrun checking on o_pack_err.

`ifndef SDMA_CACHEDATAWIDTH
`define SDMA_CACHEDATAWIDTH 128
`endif

// state  | meaning
// IDLE   | waiting for i_inst_start
// RUN    | accepting beats and emitting full words
// FLUSH  | all bytes accepted, draining the buffer (last word may be partial)
// DONE   | one-cycle completion pulse
module sdma_rdata_pack #(
    parameter int DATA_W = `SDMA_CACHEDATAWIDTH,
    parameter int CNT_W  = 20
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_inst_start,
    input  logic [CNT_W-1:0]    i_inst_bytecnt,
    input  logic [DATA_W-1:0]   i_sdma_sportrdata,
    input  logic [DATA_W/8-1:0] i_sdma_sportrvld,
    output logic                o_sdma_sportrdy,
    output logic [DATA_W-1:0]   o_sdma_packdata,
    output logic [DATA_W/8-1:0] o_sdma_packbe,
    output logic                o_sdma_packvld,
    input  logic                i_sdma_packrdy,
    output logic                o_inst_done,
    output logic                o_pack_err
);

    localparam int NB    = DATA_W / 8;
    localparam int BUF_W = 2 * DATA_W;
    localparam int OCC_W = $clog2(2 * NB + 1);
    localparam int OFS_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [OCC_W-1:0] NB_OCC = OCC_W'(NB);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   tot_q, tot_d;
    logic [CNT_W-1:0]   acc_q, acc_d;

    logic [CNT_W-1:0]   rem;
    logic [OCC_W-1:0]   pop, in_lim, in_bytes, out_cnt, out_bytes, base;
    logic [OFS_W-1:0]   ofs;
    logic [DATA_W-1:0]  packed_raw, packed_m, keep_bits;
    logic [NB-1:0]      keep, be;
    logic [BUF_W-1:0]   buf_sh, ins, ins_msk;
    logic               rdy, accept, vld, xfer;

    always_comb begin
        pop = '0;
        ofs = '0;
        for (int j = NB - 1; j >= 0; j--) begin
            if (i_sdma_sportrvld[j]) ofs = OFS_W'(j);
        end
        for (int j = 0; j < NB; j++) begin
            pop = pop + OCC_W'(i_sdma_sportrvld[j]);
        end
    end

`ifdef SDMA_PACK_ERRCHK_EN
    // General compaction so that even a malformed mask keeps every set byte in order.
    always_comb begin
        int k;
        packed_raw = '0;
        k = 0;
        for (int j = 0; j < NB; j++) begin
            if (i_sdma_sportrvld[j]) begin
                packed_raw[k*8 +: 8] = i_sdma_sportrdata[j*8 +: 8];
                k = k + 1;
            end
        end
    end
`else
    always_comb packed_raw = i_sdma_sportrdata >> {ofs, 3'b000};
`endif

    always_comb begin
        rem      = tot_q - acc_q;
        in_lim   = (CNT_W'(pop) > rem) ? rem[OCC_W-1:0] : pop;
        rdy      = (state_q == ST_RUN) && (occ_q <= NB_OCC);
        accept   = rdy && (|i_sdma_sportrvld);
        in_bytes = accept ? in_lim : '0;
        for (int j = 0; j < NB; j++) begin
            keep[j]             = OCC_W'(j) < in_bytes;
            keep_bits[j*8 +: 8] = {8{keep[j]}};
        end
        packed_m = packed_raw & keep_bits;
    end

    always_comb begin
        out_cnt = (occ_q > NB_OCC) ? NB_OCC : occ_q;
        vld     = 1'b0;
        be      = '0;
        case (state_q)
            ST_RUN: begin
                vld = occ_q >= NB_OCC;
                be  = '1;
            end
            ST_FLUSH: begin
                vld = occ_q != '0;
                for (int j = 0; j < NB; j++) be[j] = OCC_W'(j) < out_cnt;
            end
            default: ;
        endcase
        for (int j = 0; j < NB; j++) begin
            o_sdma_packdata[j*8 +: 8] = be[j] ? buf_q[j*8 +: 8] : 8'h00;
        end
        xfer      = vld && i_sdma_packrdy;
        out_bytes = xfer ? out_cnt : '0;
    end

    // New bytes land right behind whatever survives this cycle's output shift.
    always_comb begin
        base    = occ_q - out_bytes;
        buf_sh  = buf_q >> {out_bytes, 3'b000};
        ins     = BUF_W'(packed_m) << {base, 3'b000};
        ins_msk = BUF_W'(keep_bits) << {base, 3'b000};
    end

    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        acc_d   = acc_q;
        occ_d   = occ_q - out_bytes + in_bytes;
        buf_d   = (buf_sh & ~ins_msk) | ins;
        case (state_q)
            ST_IDLE: begin
                if (i_inst_start) begin
                    tot_d   = i_inst_bytecnt;
                    acc_d   = '0;
                    occ_d   = '0;
                    buf_d   = '0;
                    state_d = (i_inst_bytecnt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_d = acc_q + CNT_W'(in_bytes);
                    if (CNT_W'(in_bytes) == rem) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (occ_d == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            occ_q   <= '0;
            tot_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            occ_q   <= occ_d;
            tot_q   <= tot_d;
            acc_q   <= acc_d;
        end
    end

`ifdef SDMA_PACK_ERRCHK_EN
    logic          err_q, err_d;
    logic          noncontig;
    logic [NB-1:0] run;

    always_comb begin
        run       = i_sdma_sportrvld >> ofs;
        noncontig = |(run & (run + NB'(1)));
        err_d     = err_q;
        if ((state_q == ST_IDLE) && i_inst_start) begin
            err_d = 1'b0;
        end else if (accept && (noncontig || (CNT_W'(pop) > rem))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign o_pack_err = err_q;
`else
    assign o_pack_err = 1'b0;
`endif

    assign o_sdma_sportrdy = rdy;
    assign o_sdma_packvld  = vld;
    assign o_sdma_packbe   = be;
    assign o_inst_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sdma_rdata_pack.sv
// Directed bench for sdma_rdata_pack (DATA_W=128, CNT_W=20).
module tb_sdma_rdata_pack;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_inst_start;
    logic [19:0]   i_inst_bytecnt;
    logic [127:0]  i_sdma_sportrdata;
    logic [15:0]   i_sdma_sportrvld;
    logic          o_sdma_sportrdy;
    logic [127:0]  o_sdma_packdata;
    logic [15:0]   o_sdma_packbe;
    logic          o_sdma_packvld;
    logic          i_sdma_packrdy;
    logic          o_inst_done;
    logic          o_pack_err;

    sdma_rdata_pack dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_inst_start      (i_inst_start),
        .i_inst_bytecnt    (i_inst_bytecnt),
        .i_sdma_sportrdata (i_sdma_sportrdata),
        .i_sdma_sportrvld  (i_sdma_sportrvld),
        .o_sdma_sportrdy   (o_sdma_sportrdy),
        .o_sdma_packdata   (o_sdma_packdata),
        .o_sdma_packbe     (o_sdma_packbe),
        .o_sdma_packvld    (o_sdma_packvld),
        .i_sdma_packrdy    (i_sdma_packrdy),
        .o_inst_done       (o_inst_done),
        .o_pack_err        (o_pack_err)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [127:0] q_data[$];
    logic [15:0]  q_be[$];
    int done_cnt      = 0;
    int done_cyc      = 0;
    int last_xfer_cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_sdma_packvld && i_sdma_packrdy) begin
            q_data.push_back(o_sdma_packdata);
            q_be.push_back(o_sdma_packbe);
            last_xfer_cyc = cyc;
        end
        if (o_inst_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [127:0] seq_word(input int first);
        logic [127:0] w;
        for (int j = 0; j < 16; j++) w[j*8 +: 8] = 8'(first + j);
        return w;
    endfunction

    task automatic start_inst(input logic [19:0] n);
        i_inst_start   = 1'b1;
        i_inst_bytecnt = n;
        tick();
        i_inst_start   = 1'b0;
    endtask

    task automatic send_beat(input string tag, input logic [127:0] d, input logic [15:0] m);
        logic ok;
        ok = 1'b0;
        i_sdma_sportrdata = d;
        i_sdma_sportrvld  = m;
        for (int i = 0; i < 200; i++) begin
            if (o_sdma_sportrdy) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        i_sdma_sportrvld = '0;
        chk(tag, ok, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < 200; i++) begin
            if (done_cnt > c0) break;
            tick();
        end
        chk(tag, (done_cnt > c0), 1'b1);
    endtask

    int           qb, dc, t0;
    logic [127:0] exp_w;
    logic         exp_err;

    initial begin
        i_rst             = 1'b1;
        i_inst_start      = 1'b0;
        i_inst_bytecnt    = '0;
        i_sdma_sportrdata = '0;
        i_sdma_sportrvld  = '0;
        i_sdma_packrdy    = 1'b1;
        tick();
        tick();
        chk("rst_sportrdy", o_sdma_sportrdy, 1'b0);
        chk("rst_packvld",  o_sdma_packvld,  1'b0);
        chk("rst_packbe",   o_sdma_packbe,   16'h0);
        chk("rst_packdata", o_sdma_packdata, 128'h0);
        chk("rst_done",     o_inst_done,     1'b0);
        chk("rst_err",      o_pack_err,      1'b0);
        i_rst = 1'b0;
        tick();

        // 64 bytes of full beats at full rate
        qb = q_data.size();
        dc = done_cnt;
        start_inst(20'd64);
        t0 = cyc;
        for (int b = 0; b < 4; b++) send_beat("t1_beat", seq_word(b * 16), 16'hFFFF);
        wait_done("t1_done");
        chk("t1_nwords", 128'(q_data.size() - qb), 128'd4);
        for (int w = 0; w < 4; w++) begin
            chk("t1_data", q_data[qb + w], seq_word(w * 16));
            chk("t1_be",   q_be[qb + w],   16'hFFFF);
        end
        chk("t1_done_lat",    128'(done_cyc), 128'(last_xfer_cyc + 1));
        chk("t1_throughput",  128'(done_cyc - t0), 128'd5);
        tick();
        tick();
        chk("t1_done_once", 128'(done_cnt - dc), 128'd1);

        // offset mask then low mask, 20 bytes
        qb = q_data.size();
        start_inst(20'd20);
        send_beat("t2_beat0", seq_word(8'hA0), 16'hFFF0);
        send_beat("t2_beat1", seq_word(8'hC0), 16'h00FF);
        wait_done("t2_done");
        chk("t2_nwords", 128'(q_data.size() - qb), 128'd2);
        exp_w = '0;
        for (int j = 0; j < 12; j++) exp_w[j*8 +: 8] = 8'(8'hA4 + j);
        for (int j = 12; j < 16; j++) exp_w[j*8 +: 8] = 8'(8'hC0 + j - 12);
        chk("t2_w0_data", q_data[qb], exp_w);
        chk("t2_w0_be",   q_be[qb],   16'hFFFF);
        exp_w = '0;
        for (int j = 0; j < 4; j++) exp_w[j*8 +: 8] = 8'(8'hC4 + j);
        chk("t2_w1_data", q_data[qb + 1], exp_w);
        chk("t2_w1_be",   q_be[qb + 1],   16'h000F);

        // backpressure: buffer fills to 32 bytes, then drains in order
        i_sdma_packrdy = 1'b0;
        qb = q_data.size();
        start_inst(20'd48);
        send_beat("t3_beat0", seq_word(8'h10), 16'hFFFF);
        send_beat("t3_beat1", seq_word(8'h20), 16'hFFFF);
        i_sdma_sportrdata = seq_word(8'h30);
        i_sdma_sportrvld  = 16'hFFFF;
        tick();
        tick();
        tick();
        chk("t3_sportrdy_low", o_sdma_sportrdy, 1'b0);
        chk("t3_vld_held",     o_sdma_packvld,  1'b1);
        chk("t3_data_held",    o_sdma_packdata, seq_word(8'h10));
        chk("t3_be_held",      o_sdma_packbe,   16'hFFFF);
        chk("t3_no_xfer",      128'(q_data.size() - qb), 128'd0);
        i_sdma_packrdy = 1'b1;
        send_beat("t3_beat2", seq_word(8'h30), 16'hFFFF);
        wait_done("t3_done");
        chk("t3_nwords", 128'(q_data.size() - qb), 128'd3);
        for (int w = 0; w < 3; w++) chk("t3_data", q_data[qb + w], seq_word(16 + w * 16));

        // zero-length instruction, then start ignored while running
        qb = q_data.size();
        i_inst_start   = 1'b1;
        i_inst_bytecnt = 20'd0;
        tick();
        i_inst_start = 1'b0;
        chk("t4_done_hi",  o_inst_done,    1'b1);
        chk("t4_no_vld",   o_sdma_packvld, 1'b0);
        tick();
        chk("t4_done_lo",  o_inst_done,    1'b0);
        chk("t4_no_words", 128'(q_data.size() - qb), 128'd0);
        start_inst(20'd16);
        i_inst_start   = 1'b1;
        i_inst_bytecnt = 20'd32;
        tick();
        i_inst_start = 1'b0;
        send_beat("t4_beat", seq_word(8'h70), 16'hFFFF);
        wait_done("t4_done_run");
        chk("t4_nwords", 128'(q_data.size() - qb), 128'd1);
        chk("t4_data",   q_data[qb], seq_word(8'h70));

        // overrun: 10 bytes wanted, 16 offered
        qb = q_data.size();
        start_inst(20'd10);
        send_beat("t5_beat", seq_word(8'h50), 16'hFFFF);
        wait_done("t5_done");
        chk("t5_nwords", 128'(q_data.size() - qb), 128'd1);
        exp_w = '0;
        for (int j = 0; j < 10; j++) exp_w[j*8 +: 8] = 8'(8'h50 + j);
        chk("t5_data", q_data[qb], exp_w);
        chk("t5_be",   q_be[qb],   16'h03FF);
`ifdef SDMA_PACK_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        chk("t5_err", o_pack_err, exp_err);

        // reset mid-instruction with 8 bytes buffered
        start_inst(20'd32);
        chk("t6_err_cleared", o_pack_err, 1'b0);
        send_beat("t6_beat0", seq_word(8'h80), 16'h00FF);
        chk("t6_partial_no_vld", o_sdma_packvld, 1'b0);
        dc = done_cnt;
        i_rst = 1'b1;
        tick();
        chk("t6_sportrdy", o_sdma_sportrdy, 1'b0);
        chk("t6_packvld",  o_sdma_packvld,  1'b0);
        chk("t6_packbe",   o_sdma_packbe,   16'h0);
        chk("t6_packdata", o_sdma_packdata, 128'h0);
        chk("t6_done",     o_inst_done,     1'b0);
        chk("t6_err",      o_pack_err,      1'b0);
        i_rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_no_done", 128'(done_cnt - dc), 128'd0);
        qb = q_data.size();
        start_inst(20'd16);
        send_beat("t6_beat1", seq_word(8'h90), 16'hFFFF);
        wait_done("t6_done_after");
        chk("t6_nwords", 128'(q_data.size() - qb), 128'd1);
        chk("t6_data",   q_data[qb], seq_word(8'h90));
        chk("t6_be",     q_be[qb],   16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
